// File: rtl/fetch_controller.sv
// fetch_controller
//
// Purpose:
//   Sequences instruction fetch into the instruction buffer. Issues
//   word-aligned requests to instruction memory, writes returned instructions
//   into the buffer with zero latency, and uses a credit scheme so that
//   buffered entries plus in-flight requests never exceed the buffer depth.
//   A redirect flushes the buffer and discards in-flight responses that were
//   requested before the redirect.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   enable          permits new requests (responses are always accepted)
//   redirect_valid  one-cycle redirect pulse from the branch unit
//   redirect_pc     redirect target (low two bits ignored)
//   imem_req_valid  request valid to instruction memory
//   imem_req_ready  memory accepts the request
//   imem_req_addr   request address (equals fetch_pc)
//   imem_resp_valid in-order response valid
//   imem_resp_data  response instruction
//   buf_write_en    write strobe to the instruction buffer
//   buf_data        write data to the instruction buffer
//   buf_flush       buffer flush pulse
//   buf_pop         consumer removed one buffer entry
//   fetch_pc        next address to request
//   outstanding     number of in-flight requests
//   busy            high whenever the controller is not idle

module fetch_controller #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INST_WIDTH      = 32,
  parameter int                    BUFFER_DEPTH    = 8,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic                                 redirect_valid,
  input  logic [ADDR_WIDTH-1:0]                redirect_pc,
  output logic                                 imem_req_valid,
  input  logic                                 imem_req_ready,
  output logic [ADDR_WIDTH-1:0]                imem_req_addr,
  input  logic                                 imem_resp_valid,
  input  logic [INST_WIDTH-1:0]                imem_resp_data,
  output logic                                 buf_write_en,
  output logic [INST_WIDTH-1:0]                buf_data,
  output logic                                 buf_flush,
  input  logic                                 buf_pop,
  output logic [ADDR_WIDTH-1:0]                fetch_pc,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 busy
);

  localparam int OCC_W = $clog2(BUFFER_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  // occ and outstanding are each bounded by BUFFER_DEPTH, so one extra bit
  // holds their sum without overflow.
  localparam int SUM_W = OCC_W + 1;

  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [OUT_W-1:0]      r_outstanding;
  logic [OUT_W-1:0]      w_out_nxt;
  logic [OCC_W-1:0]      r_occ;
  logic [OCC_W-1:0]      w_occ_nxt;

  logic                  w_in_fetch;
  logic                  w_credit_ok;
  logic                  w_slot_ok;
  logic                  w_accept;
  logic                  w_resp_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH-1:0] w_redirect_aligned;

  assign w_in_fetch         = (r_state == ST_FETCH);
  assign w_redirect_aligned = redirect_pc & ~(ADDR_WIDTH'(3));

  // A new request needs a free buffer slot that no in-flight request has
  // already claimed, plus a free outstanding slot.
  assign w_credit_ok = (SUM_W'(r_occ) + SUM_W'(r_outstanding)) < SUM_W'(BUFFER_DEPTH);
  assign w_slot_ok   = r_outstanding < OUT_W'(MAX_OUTSTANDING);

  assign imem_req_valid = w_in_fetch & enable & ~redirect_valid & w_credit_ok & w_slot_ok;
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid & imem_req_ready;

  // A response with nothing in flight is a protocol error and is dropped.
  assign w_resp_ok = imem_resp_valid & (r_outstanding != '0);

  // Only FETCH-state responses are live; in DRAIN, or on a redirect cycle,
  // the response belongs to the old instruction stream and is discarded.
  assign buf_write_en = w_resp_ok & w_in_fetch & ~redirect_valid;
  assign buf_data     = imem_resp_data;
  assign buf_flush    = redirect_valid & (r_state != ST_IDLE);

  assign w_pop_ok = buf_pop & (r_occ != '0);

  assign fetch_pc    = r_fetch_pc;
  assign outstanding = r_outstanding;
  assign busy        = (r_state != ST_IDLE);

  always_comb begin
    w_out_nxt = r_outstanding;
    case ({w_accept, w_resp_ok})
      2'b10:   w_out_nxt = r_outstanding + OUT_ONE;
      2'b01:   w_out_nxt = r_outstanding - OUT_ONE;
      default: w_out_nxt = r_outstanding;
    endcase
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (redirect_valid) begin
      w_occ_nxt = '0;
    end else begin
      case ({buf_write_en, w_pop_ok})
        2'b10:   w_occ_nxt = r_occ + OCC_ONE;
        2'b01:   w_occ_nxt = r_occ - OCC_ONE;
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) w_state_nxt = (w_out_nxt != '0) ? ST_DRAIN : ST_FETCH;
      end
      ST_DRAIN: begin
        // Leaves as soon as the last stale response is gone; a redirect here
        // needs no special case since all in-flight data is stale anyway.
        w_state_nxt = (w_out_nxt != '0) ? ST_DRAIN : ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_occ         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      r_occ         <= w_occ_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      end
    end
  end

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    ((SUM_W'(r_occ) + SUM_W'(r_outstanding)) <= SUM_W'(BUFFER_DEPTH)));

endmodule
